// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, grant owner and default bus widths.
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one SRAM-like bus, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of DATA always winning.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output state_t              fsm_state,
  output grant_t              fsm_grant
);

  // Handshake: a requester holds req (and fields) until its addr_ok pulse; the
  // memory accepts with mem_addr_ok while mem_req=1 and later completes with one
  // mem_data_ok pulse, which is forwarded as the granted requester's data_ok.

  state_t state;
  grant_t grant;
  grant_t next_grant;
  logic   in_addr;
  logic   in_resp;
  logic   is_data;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;

  always_comb begin
    next_grant = data_req ? GNT_DATA : GNT_INST;
    if (inst_req && data_req)
      next_grant = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
  end
`else
  always_comb begin
    next_grant = data_req ? GNT_DATA : GNT_INST;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= GNT_INST;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= GNT_DATA;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            grant <= next_grant;
            state <= ST_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= next_grant;
`endif
          end
        end
        ST_ADDR: if (mem_addr_ok) state <= ST_RESP;
        ST_RESP: if (mem_data_ok) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gating with reset keeps every pulse low during the reset cycle itself.
  assign in_addr = (state == ST_ADDR) && !reset;
  assign in_resp = (state == ST_RESP) && !reset;
  assign is_data = (grant == GNT_DATA);

  assign mem_req   = in_addr;
  assign mem_wr    = in_addr && is_data && data_wr;
  assign mem_wstrb = (in_addr && is_data) ? data_wstrb : '0;
  assign mem_wdata = (in_addr && is_data) ? data_wdata : '0;
  assign mem_addr  = !in_addr ? '0 : (is_data ? data_addr : inst_addr);

  assign inst_addr_ok = in_addr && mem_addr_ok && !is_data;
  assign data_addr_ok = in_addr && mem_addr_ok && is_data;
  assign inst_data_ok = in_resp && mem_data_ok && !is_data;
  assign data_data_ok = in_resp && mem_data_ok && is_data;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign fsm_state = state;
  assign fsm_grant = grant;

endmodule
